// File: rtl/sram_1rw_req_ctrl.sv
// Request front-end for a 1RW synchronous SRAM macro with 1-cycle registered read data.
// Drives the macro pins combinationally on accept and returns read data in order through a small fall-through FIFO.
module sram_1rw_req_ctrl #(
   parameter int BITS       = 256,
   parameter int ADDR_WIDTH = 12,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [BITS-1:0]       req_wdata,
   input  logic [BITS-1:0]       req_wmask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [BITS-1:0]       rsp_rdata,
   output logic                  sram_ce,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [BITS-1:0]       sram_wd,
   output logic [BITS-1:0]       sram_wmask,
   input  logic [BITS-1:0]       sram_rd
);

   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(RSP_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RSP_DEPTH - 1);

   logic [BITS-1:0]  fifo_mem [RSP_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             rd_pend;
   logic [CNT_W:0]   occupancy;
   logic             fire;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // A pending read already owns a slot, so accepting only below depth makes overflow impossible.
   assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, rd_pend};
   assign req_ready  = !rst && (occupancy < DEPTH_OCC);
   assign fire       = req_valid && req_ready;

   assign sram_ce    = fire;
   assign sram_we    = fire && req_we;
   assign sram_addr  = fire ? req_addr  : '0;
   assign sram_wd    = fire ? req_wdata : '0;
   assign sram_wmask = fire ? req_wmask : '0;

   assign fifo_empty = (count == '0);
   assign rsp_valid  = rd_pend || !fifo_empty;
   assign rsp_rdata  = fifo_empty ? sram_rd : fifo_mem[rd_ptr];
   // Fresh data bypasses the FIFO only when nothing older is queued and the consumer takes it now.
   assign push       = rd_pend && !(fifo_empty && rsp_ready);
   assign pop        = !fifo_empty && rsp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend <= 1'b0;
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         rd_pend <= fire && !req_we;
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= sram_rd;
   end

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Bench for sram_1rw_req_ctrl: behavioural SRAM macro, queue-based response model, directed and random traffic.
module tb_sram_1rw_req_ctrl;
   localparam int BITS  = 256;
   localparam int AW    = 12;
   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req_valid, req_ready, req_we;
   logic [AW-1:0]   req_addr;
   logic [BITS-1:0] req_wdata, req_wmask;
   logic            rsp_valid, rsp_ready;
   logic [BITS-1:0] rsp_rdata;
   logic            sram_ce, sram_we;
   logic [AW-1:0]   sram_addr;
   logic [BITS-1:0] sram_wd, sram_wmask, sram_rd;

   always #10 clk = ~clk;

   sram_1rw_req_ctrl #(.BITS(BITS), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wd(sram_wd), .sram_wmask(sram_wmask), .sram_rd(sram_rd)
   );

   // Behavioural 1RW macro: masked write, registered read output.
   logic [BITS-1:0] mac [int];
   function automatic logic [BITS-1:0] mac_rd(input int a);
      return mac.exists(a) ? mac[a] : '0;
   endfunction
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) mac[int'(sram_addr)] = (sram_wd & sram_wmask) | (mac_rd(int'(sram_addr)) & ~sram_wmask);
         else         sram_rd <= mac_rd(int'(sram_addr));
      end
   end

   // Reference model: memory contents as seen by accepted requests, plus the ordered list of owed read data.
   logic [BITS-1:0] ref_mem [int];
   logic [BITS-1:0] exp_q [$];
   logic [BITS-1:0] got_q [$];
   bit              fired;
   int              checks = 0;
   int              errors = 0;

   function automatic logic [BITS-1:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : '0;
   endfunction

   task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout expected=event", name);
   endtask

   task automatic compare_cycle();
      bit e_ready, e_valid, e_fire;
      int a;
      if (rst) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_sram_ce", sram_ce, 0);
         chk("rst_sram_we", sram_we, 0);
         chk("rst_sram_addr", sram_addr, 0);
         chk("rst_sram_wd", sram_wd, 0);
         chk("rst_sram_wmask", sram_wmask, 0);
         exp_q.delete();
         fired = 0;
         return;
      end
      e_ready = exp_q.size() < DEPTH;
      e_valid = exp_q.size() > 0;
      e_fire  = req_valid && e_ready;
      a       = int'(req_addr);
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_valid);
      chk("sram_ce", sram_ce, e_fire);
      chk("sram_we", sram_we, e_fire && req_we);
      chk("sram_addr", sram_addr, e_fire ? req_addr : '0);
      chk("sram_wd", sram_wd, e_fire ? req_wdata : '0);
      chk("sram_wmask", sram_wmask, e_fire ? req_wmask : '0);
      if (e_valid) chk("rsp_rdata", rsp_rdata, exp_q[0]);
      if (e_valid && rsp_ready) begin
         got_q.push_back(rsp_rdata);
         void'(exp_q.pop_front());
      end
      if (e_fire) begin
         if (req_we) ref_mem[a] = (req_wdata & req_wmask) | (ref_rd(a) & ~req_wmask);
         else        exp_q.push_back(ref_rd(a));
      end
      fired = e_fire;
   endtask

   // Compare at the falling edge, then hand control back 2 time units after the next rising edge.
   task automatic cycle();
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic set_idle();
      req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wmask = '0;
   endtask

   task automatic do_req(input bit we, input int addr, input logic [BITS-1:0] wd, input logic [BITS-1:0] wm);
      bit done = 0;
      req_valid = 1; req_we = we; req_addr = AW'(addr); req_wdata = wd; req_wmask = wm;
      for (int i = 0; i < 50 && !done; i++) begin
         cycle();
         done = fired;
      end
      if (!done) timeout("do_req_accept");
      set_idle();
   endtask

   initial begin
      logic [BITS-1:0] d [5];
      int k;
      int n0;
      set_idle();
      rsp_ready = 1;
      for (int i = 1; i <= 4; i++) d[i] = {32{8'(8'h10 * i)}};

      cycle();
      chk("reset_req_ready_lit", req_ready, 0);
      cycle();
      rst = 0;
      cycle();

      // write then read back, full mask
      got_q.delete();
      do_req(1, 5, {32{8'hA5}}, '1);
      do_req(0, 5, '0, '0);
      cycle();
      chk("t2_rsp_count", got_q.size(), 1);
      if (got_q.size() > 0) chk("t2_rdata", got_q[0], {32{8'hA5}});

      // partial mask write
      got_q.delete();
      do_req(1, 5, {32{8'hFF}}, BITS'(8'hFF));
      do_req(0, 5, '0, '0);
      cycle();
      chk("t3_rsp_count", got_q.size(), 1);
      if (got_q.size() > 0) chk("t3_rdata", got_q[0], {{31{8'hA5}}, 8'hFF});

      // stall with rsp_ready low, then drain in order
      for (int i = 1; i <= 4; i++) do_req(1, i, d[i], '1);
      got_q.delete();
      k = 1;
      for (int c = 0; c < 80 && got_q.size() < 4; c++) begin
         if (k <= 4) begin req_valid = 1; req_we = 0; req_addr = AW'(k); end
         else set_idle();
         rsp_ready = (c >= 6);
         if (c == 3) begin
            #1;
            chk("t4_stall_ready", req_ready, 0);
            chk("t4_stall_ce", sram_ce, 0);
            chk("t4_accepts", k, 3);
         end
         cycle();
         if (fired) k++;
      end
      set_idle();
      chk("t4_rsp_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < got_q.size()) chk("t4_order", got_q[i], d[i+1]);

      // full FIFO, then one response per cycle with requests held
      got_q.delete();
      rsp_ready = 0;
      n0 = -1;
      for (int c = 0; c < 12; c++) begin
         req_valid = 1; req_we = 0; req_addr = AW'(1 + c % 4);
         rsp_ready = (c >= 4);
         cycle();
         if (c == 3) n0 = got_q.size();
      end
      chk("t5_before", n0, 0);
      chk("t5_throughput", got_q.size(), 8);
      set_idle();
      rsp_ready = 1;
      for (int i = 0; i < 4; i++) cycle();

      // async reset between edges while busy
      rsp_ready = 0;
      do_req(0, 3, '0, '0);
      req_valid = 1; req_we = 0; req_addr = AW'(4);
      #1;
      chk("t1_pre_ready", req_ready, 1);
      chk("t1_pre_valid", rsp_valid, 1);
      chk("t1_pre_ce", sram_ce, 1);
      #2 rst = 1;
      #1;
      chk("t1_ready", req_ready, 0);
      chk("t1_valid", rsp_valid, 0);
      chk("t1_ce", sram_ce, 0);
      chk("t1_we", sram_we, 0);
      cycle();
      rst = 0;
      set_idle();
      rsp_ready = 1;
      cycle();

      // read in flight dropped by reset pulse
      got_q.delete();
      do_req(0, 2, '0, '0);
      rst = 1;
      cycle();
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t6_valid", rsp_valid, 0);
      end
      chk("t6_no_rsp", got_q.size(), 0);

      // randomized traffic
      for (int seg = 0; seg < 6; seg++) begin
         int pv, pr;
         pv = 30 + 14 * seg;
         pr = (seg % 2 == 0) ? 90 : 35;
         for (int c = 0; c < 300; c++) begin
            req_valid = ($urandom_range(0, 99) < pv);
            req_we    = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 2))
               0:       req_wmask = '1;
               1:       req_wmask = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
               default: req_wmask = '0;
            endcase
            rsp_ready = ($urandom_range(0, 99) < pr);
            rst       = ($urandom_range(0, 249) == 0);
            cycle();
         end
      end
      rst = 0;
      set_idle();
      rsp_ready = 1;
      for (int i = 0; i < 6; i++) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
